// File: rtl/dnn_pkg.sv
// rtl/dnn_pkg.sv - shared constants and state type for the DNN loader
package dnn_pkg;

  localparam int NUM_W1 = 16;
  localparam int NUM_W2 = 8;
  localparam int NUM_W  = NUM_W1 + NUM_W2;
  localparam int NUM_X  = 4;
  localparam int W_W    = 5;

  localparam logic CMD_W = 1'b0;
  localparam logic CMD_X = 1'b1;

  typedef enum logic [1:0] {IDLE, FIRE, WAIT} ld_state_t;

endpackage

// File: rtl/dnn_wbank.sv
// rtl/dnn_wbank.sv - indexed weight register bank with flattened read-out
module dnn_wbank import dnn_pkg::*; #(
  parameter int WIDTH = W_W,
  parameter int DEPTH = NUM_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [WIDTH-1:0]           wdata,
  output logic [DEPTH*WIDTH-1:0]     w_bus
);

  logic [WIDTH-1:0] bank [DEPTH];

  // one slot written per weight beat; reset clears so the datapath sees zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        bank[k] <= '0;
      end
    end else if (we) begin
      bank[idx] <= wdata;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign w_bus[k*WIDTH +: WIDTH] = bank[k];
  end

endmodule

// File: rtl/dnn_loader.sv
// rtl/dnn_loader.sv - beat-stream loader feeding weights and inputs to the 4-4-2 DNN datapath
module dnn_loader
  import dnn_pkg::NUM_W, dnn_pkg::NUM_X, dnn_pkg::CMD_W, dnn_pkg::CMD_X,
         dnn_pkg::ld_state_t, dnn_pkg::IDLE, dnn_pkg::FIRE, dnn_pkg::WAIT;
#(
  parameter int I_W     = 7,
  parameter int W_W     = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_cmd,
  input  logic [7:0]            s_data,
  output logic [NUM_W*W_W-1:0]  w_bus,
  output logic signed [I_W-1:0] x0,
  output logic signed [I_W-1:0] x1,
  output logic signed [I_W-1:0] x2,
  output logic signed [I_W-1:0] x3,
  output logic                  in_ready,
  input  logic                  out0_ready,
  output logic                  busy,
  output logic [1:0]            err,
  input  logic                  err_clr
);

  if (I_W < 2 || I_W > 8) begin : g_bad_i_w
    $error("dnn_loader: I_W must be 2..8");
  end
  if (W_W != dnn_pkg::W_W) begin : g_bad_w_w
    $error("dnn_loader: W_W must match the datapath weight width");
  end
  if (TIMEOUT < 8 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("dnn_loader: TIMEOUT must be 8..65535");
  end

  localparam int IDX_W = $clog2(NUM_W);
  localparam int XI_W  = $clog2(NUM_X);
  localparam int CNT_W = 16;
  localparam logic [IDX_W-1:0] W_LAST   = IDX_W'(NUM_W - 1);
  localparam logic [XI_W-1:0]  X_LAST   = XI_W'(NUM_X - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ld_state_t        state, state_nx;
  logic             alive;
  logic [IDX_W-1:0] w_idx;
  logic [XI_W-1:0]  x_idx;
  logic             w_loaded;
  logic             seen_low;
  logic [CNT_W-1:0] cnt;
  logic [I_W-1:0]   x_reg [NUM_X];
  logic             accept, w_beat, x_beat, x_take, done, tmo;
  logic [1:0]       err_set;
  logic             unused_data;

  // upper data bits are don't-care for both beat kinds
  assign unused_data = ^s_data;

  // alive holds s_ready low through the reset cycle without a path from rst
  assign s_ready  = alive && (state == IDLE);
  assign accept   = s_valid && s_ready;
  assign w_beat   = accept && (s_cmd == CMD_W);
  assign x_beat   = accept && (s_cmd == CMD_X);
  assign x_take   = x_beat && w_loaded;
  assign done     = (state == WAIT) && out0_ready && seen_low;
  assign tmo      = (state == WAIT) && (cnt == CNT_LAST);
  assign err_set  = {tmo && !done, x_beat && !w_loaded};
  assign in_ready = (state == FIRE);
  assign busy     = (state != IDLE);
  assign x0       = x_reg[0];
  assign x1       = x_reg[1];
  assign x2       = x_reg[2];
  assign x3       = x_reg[3];

  dnn_wbank #(
    .WIDTH (W_W),
    .DEPTH (NUM_W)
  ) u_wbank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_beat),
    .idx   (w_idx),
    .wdata (s_data[W_W-1:0]),
    .w_bus (w_bus)
  );

  // state register and post-reset enable for s_ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
    end
  end

  // next state: gather in IDLE, single FIRE cycle, WAIT for result or timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (x_take && x_idx == X_LAST) state_nx = FIRE;
      FIRE:    state_nx = WAIT;
      WAIT:    if (done || tmo) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // beat bookkeeping: weight slot index, input slot index and input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx    <= '0;
      w_loaded <= 1'b0;
      x_idx    <= '0;
      for (int k = 0; k < NUM_X; k++) begin
        x_reg[k] <= '0;
      end
    end else if (w_beat) begin
      w_idx <= (w_idx == W_LAST) ? '0 : w_idx + 1'b1;
      if (w_idx == W_LAST) w_loaded <= 1'b1;
      x_idx <= '0;
    end else if (x_take) begin
      x_reg[x_idx] <= s_data[I_W-1:0];
      x_idx        <= x_idx + 1'b1;
    end
  end

  // WAIT timeout counter and low-seen flag, both rearmed on FIRE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      seen_low <= 1'b0;
    end else if (state == FIRE) begin
      cnt      <= '0;
      seen_low <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
      if (!out0_ready) seen_low <= 1'b1;
    end
  end

  // sticky error flags; a new error outranks a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 2'b00;
    end else begin
      err <= (err_clr ? 2'b00 : err) | err_set;
    end
  end

endmodule

// File: tb/tb_dnn_loader.sv
// tb/tb_dnn_loader.sv - table-driven and directed bench for dnn_loader
`timescale 1ns/1ps
module tb_dnn_loader;

  localparam int I_W     = 7;
  localparam int W_W     = 5;
  localparam int TIMEOUT = 16;
  localparam int WB      = 24 * W_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_cmd;
  logic [7:0]            s_data;
  logic [WB-1:0]         w_bus;
  logic signed [I_W-1:0] x0, x1, x2, x3;
  logic                  in_ready;
  logic                  out0_ready;
  logic                  busy;
  logic [1:0]            err;
  logic                  err_clr;

  dnn_loader #(
    .I_W     (I_W),
    .W_W     (W_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_cmd      (s_cmd),
    .s_data     (s_data),
    .w_bus      (w_bus),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .in_ready   (in_ready),
    .out0_ready (out0_ready),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ir_cnt = 0;

  always @(negedge clk) begin
    if (in_ready) ir_cnt <= ir_cnt + 1;
  end

  typedef struct {
    logic       v;
    logic       cmd;
    logic [7:0] d;
    logic       o;
    logic       clr;
    logic       e_srdy;
    logic       e_irdy;
    logic       e_busy;
    logic [1:0] e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, cmd, input logic [7:0] d, input logic o, clr,
                              e_srdy, e_irdy, e_busy, input logic [1:0] e_err);
    vec_t t;
    t.v = v; t.cmd = cmd; t.d = d; t.o = o; t.clr = clr;
    t.e_srdy = e_srdy; t.e_irdy = e_irdy; t.e_busy = e_busy; t.e_err = e_err;
    tbl.push_back(t);
  endfunction

  function automatic logic [WB-1:0] fill(input logic [W_W-1:0] v);
    logic [WB-1:0] r;
    for (int k = 0; k < 24; k++) r[k*W_W +: W_W] = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic cmd, input logic [7:0] d);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_wait: s_ready got 0 expected 1 within 50 cycles");
    end
    s_valid = 1'b1; s_cmd = cmd; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic load_weights(input logic [7:0] d);
    for (int k = 0; k < 24; k++) send(1'b0, d);
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, e);
    send(1'b1, a); send(1'b1, b); send(1'b1, c); send(1'b1, e);
  endtask

  // called on the FIRE cycle; a stale high out0_ready must not end WAIT
  task automatic finish_frame(input string tag);
    @(negedge clk);
    check({tag, "_pulse"}, in_ready, 1'b0);
    out0_ready = 1'b1;
    @(negedge clk);
    check({tag, "_stale_high"}, busy, 1'b1);
    out0_ready = 1'b0;
    @(negedge clk);
    out0_ready = 1'b1;
    @(negedge clk);
    check({tag, "_exit_busy"}, busy, 1'b0);
    check({tag, "_exit_srdy"}, s_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_cmd = 1'b0; s_data = 8'h00; out0_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 2'b00);
    check("rst_w_bus", w_bus, '0);
    check("rst_x0", $unsigned(x0), 7'h00);
    check("rst_x3", $unsigned(x3), 7'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready_after", s_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ir0;
    int n;
    logic [7:0] vals [4];
    logic [WB-1:0] exp_w;

    do_reset();

    // input before weights, clear vs set, full load, frame, handshake
    add(1, 1, 8'h05, 0, 0, 1, 0, 0, 2'b00);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 2'b01);
    add(1, 1, 8'h05, 0, 1, 1, 0, 0, 2'b01);
    add(0, 0, 8'h00, 0, 1, 1, 0, 0, 2'b01);
    add(0, 0, 8'h00, 0, 0, 1, 0, 0, 2'b00);
    for (int k = 0; k < 24; k++) add(1, 0, 8'h01, 0, 0, 1, 0, 0, 2'b00);
    add(1, 1, 8'h03, 0, 0, 1, 0, 0, 2'b00);
    add(1, 1, 8'hFE, 0, 0, 1, 0, 0, 2'b00);
    add(1, 1, 8'h01, 0, 0, 1, 0, 0, 2'b00);
    add(1, 1, 8'h00, 0, 0, 1, 0, 0, 2'b00);
    add(0, 0, 8'h00, 0, 0, 0, 1, 1, 2'b00);
    for (int k = 0; k < 4; k++) add(0, 0, 8'h00, 0, 0, 0, 0, 1, 2'b00);
    add(0, 0, 8'h00, 1, 0, 0, 0, 1, 2'b00);
    add(0, 0, 8'h00, 1, 0, 1, 0, 0, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("v%0d_s_ready", i), s_ready, tbl[i].e_srdy);
      check($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_irdy);
      check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("v%0d_err", i), err, tbl[i].e_err);
      s_valid = tbl[i].v; s_cmd = tbl[i].cmd; s_data = tbl[i].d;
      out0_ready = tbl[i].o; err_clr = tbl[i].clr;
      @(negedge clk);
    end
    s_valid = 1'b0; err_clr = 1'b0;
    check("t1_x0", $unsigned(x0), 7'h03);
    check("t1_x1", $unsigned(x1), 7'h7E);
    check("t1_x2", $unsigned(x2), 7'h01);
    check("t1_x3", $unsigned(x3), 7'h00);
    check("t1_w_bus", w_bus, fill(5'h01));

    // timeout with out0_ready stuck low
    out0_ready = 1'b0;
    send_frame(8'h0A, 8'h14, 8'h1E, 8'h28);
    check("t4_fire", in_ready, 1'b1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t4_busy_cycles", n, 17);
    check("t4_err", err, 2'b10);
    check("t4_s_ready", s_ready, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", err, 2'b00);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    check("t4_next_fire", in_ready, 1'b1);
    finish_frame("t4_next");
    check("t4_next_err", err, 2'b00);

    // partial frame discarded by a weight beat
    ir0 = ir_cnt;
    send(1'b1, 8'h11);
    send(1'b1, 8'h12);
    send(1'b0, 8'h1F);
    send_frame(8'h05, 8'h06, 8'h07, 8'hC0);
    check("t5_fire", in_ready, 1'b1);
    finish_frame("t5");
    check("t5_pulses", ir_cnt - ir0, 1);
    check("t5_x0", $unsigned(x0), 7'h05);
    check("t5_x1", $unsigned(x1), 7'h06);
    check("t5_x2", $unsigned(x2), 7'h07);
    check("t5_x3", $unsigned(x3), 7'h40);
    exp_w = fill(5'h01);
    exp_w[4:0] = 5'h1F;
    check("t5_w_bus", w_bus, exp_w);

    // back-to-back frames with random gaps against a reference of sent values
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) vals[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b1, vals[k]);
      end
      check($sformatf("sb%0d_fire", f), in_ready, 1'b1);
      check($sformatf("sb%0d_x0", f), $unsigned(x0), vals[0][I_W-1:0]);
      check($sformatf("sb%0d_x1", f), $unsigned(x1), vals[1][I_W-1:0]);
      check($sformatf("sb%0d_x2", f), $unsigned(x2), vals[2][I_W-1:0]);
      check($sformatf("sb%0d_x3", f), $unsigned(x3), vals[3][I_W-1:0]);
      finish_frame($sformatf("sb%0d", f));
    end

    // reset during WAIT
    send_frame(8'h21, 8'h22, 8'h23, 8'h24);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6w_busy", busy, 1'b0);
    check("t6w_in_ready", in_ready, 1'b0);
    check("t6w_s_ready", s_ready, 1'b0);
    check("t6w_w_bus", w_bus, '0);
    check("t6w_x0", $unsigned(x0), 7'h00);
    @(negedge clk);
    rst = 1'b0;
    out0_ready = 1'b0;
    @(negedge clk);
    check("t6w_s_ready_after", s_ready, 1'b1);

    // reset during input gather, then a clean full frame
    ir0 = ir_cnt;
    load_weights(8'h02);
    send(1'b1, 8'h09);
    send(1'b1, 8'h09);
    rst = 1'b1;
    #1;
    check("t6g_x0", $unsigned(x0), 7'h00);
    check("t6g_w_bus", w_bus, '0);
    check("t6g_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_weights(8'h03);
    send_frame(8'h04, 8'h03, 8'h02, 8'h01);
    check("t6_fire", in_ready, 1'b1);
    finish_frame("t6");
    check("t6_pulses", ir_cnt - ir0, 1);
    check("t6_x0", $unsigned(x0), 7'h04);
    check("t6_x3", $unsigned(x3), 7'h01);
    check("t6_w_bus", w_bus, fill(5'h03));
    check("t6_err", err, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
